nxn_game_engine: RTL and testbench
==================================

# nxn_game_engine

Parametrised N×N, K-in-a-row two-player game engine: the successor to the fixed 3×3 tic-tac-toe state machine. It sits between the click decoder (one cell index per click) and the VGA painter/score decoders. It holds the board, whose turn it is and the undo history. It performs sequential win/tie detection, alternates the opening player between games and keeps saturating per-player scores.

## Interface
Parameters:
- N, 3, board side; cells indexed idx = row*N + col, 2 ≤ N ≤ 8
- K, 3, run length that wins, 2 ≤ K ≤ N
- SCORE_W, 6, score counter width
- IDX_W, $clog2(N*N), cell index width (derived)

Ports:
- CLK_100MHZ  in  1  system clock
- reset  in  1  synchronous, active-high; clears everything
- start  in  1  leave start screen (any mouse click)
- move_valid  in  1  one-cycle pulse, place current player's mark at move_idx
- move_idx  in  IDX_W  target cell
- erase  in  1  one-cycle pulse, undo last move of current game
- restart  in  1  one-cycle pulse, new game, scores kept
- score_clear  in  1  one-cycle pulse, zero both scores
- x_matrix  out  N*N  cells holding X
- o_matrix  out  N*N  cells holding O
- turnoX  out  1  1 = X to move
- move_ack  out  1  one-cycle pulse, move accepted
- move_reject  out  1  one-cycle pulse, move refused
- displayStartPlaying, displayGanadorX, displayGanadorO, displayEmpate  out  1 each  state decodes
- scoreX, scoreO  out  SCORE_W  saturating scores
- state  out  3  current state, for debug

## Operation
- States: START, PLAY, CHECK, WIN_X, WIN_O, TIE.
- START: start → PLAY. move_valid, erase and restart are ignored; no reject is raised.
- PLAY, move_valid, no erase:
  - If move_idx < N*N and the cell is empty: set the cell for the current player and push move_idx on the history stack (depth N*N). Increment move_cnt, pulse move_ack, go to CHECK.
  - Otherwise pulse move_reject; no other change.
- PLAY, erase:
  - If history is non-empty: pop, clear that cell, decrement move_cnt, toggle turnoX.
  - If empty: ignored.
  - erase wins over a simultaneous move_valid, which gets move_reject.
- CHECK: dir_cnt steps 0..3 (horizontal, vertical, diagonal, anti-diagonal), one cycle each.
  - Each cycle counts the contiguous same-player run through the last-placed cell, up to K-1 cells each side, clipped at board edges with no wrap.
  - run ≥ K sets a sticky win flag.
  - After dir 3: win → WIN_X/WIN_O by mover. Else move_cnt == N*N → TIE. Else toggle turnoX → PLAY.
- In CHECK: move_valid gets move_reject; erase is ignored.
- WIN_X/WIN_O/TIE: board frozen; move_valid and erase are ignored.
- restart in PLAY/CHECK/WIN_*/TIE:
  - Clear board, history, move_cnt and dir_cnt; go to PLAY.
  - Opener toggles: turnoX = new value of opener_x, which inverts on every restart.
  - restart has priority over move_valid and erase.
- Scores:
  - Increment by 1 on the edge entering WIN_X/WIN_O.
  - Saturate at 2^SCORE_W-1.
  - score_clear zeroes both in any state and wins over a same-edge increment.

## Timing
- Reset values:
  - state=START.
  - Board all 0, history empty, move_cnt=0.
  - turnoX=1, opener_x=1.
  - Scores 0; move_ack/move_reject 0.
  - displayStartPlaying=1, other display outputs 0.
- All outputs are registered; display outputs are decoded from the state register.
- Move sampled at edge t → cell and move_ack visible after t; state=CHECK.
- Verdict visible after edge t+4: state, turnoX toggle, score.
- Next move is acceptable at edge t+5 at the earliest.
- erase takes effect after one edge.
- restart takes effect after one edge.
- move_ack and move_reject are exactly one cycle wide and mutually exclusive.
- Back-to-back move_valid on consecutive cycles: first accepted, second rejected because the state is CHECK.
- reset asserted mid-CHECK: next edge gives reset values; no score change.

## Test plan
- N=3,K=3: start; X plays 0, O 3, X 1, O 4, X 2 → move_ack each move; state=WIN_X 4 cycles after the last ack; scoreX=1, turnoX unchanged.
- N=3: fill the board as 0,1,2,4,3,5,7,6,8 (no line) → TIE after 9th move + 4 cycles; scores unchanged. restart → board clear, turnoX=0 (O opens).
- N=5,K=4: X diagonal at 1,7,13,19 with O elsewhere → WIN_X. Three X in a row along an edge (0,1,2) → no win.
- Occupied cell, move_idx=9 with N=3, move during CHECK, move+erase same cycle → each gives move_reject with the board unchanged. The same-cycle case also undoes the previous move.
- Three moves, then three erases, then a fourth erase → board empty, turnoX back to the opener, fourth erase ignored.
- SCORE_W=2: four X wins → scoreX holds 3. score_clear on the edge entering WIN_X → scoreX=0. reset in CHECK → START, all outputs at reset values.

Source files
------------

// File: rtl/nxn_game_engine.sv
// N x N, K-in-a-row two-player engine: board, turn, undo history, sequential
// four-direction win scan after each move, alternating opener, saturating scores.
module nxn_game_engine #(
   parameter int N       = 3,
   parameter int K       = 3,
   parameter int SCORE_W = 6,
   parameter int IDX_W   = $clog2(N*N)
) (
   input  logic               CLK_100MHZ,
   input  logic               reset,
   input  logic               start,
   input  logic               move_valid,
   input  logic [IDX_W-1:0]   move_idx,
   input  logic               erase,
   input  logic               restart,
   input  logic               score_clear,
   output logic [N*N-1:0]     x_matrix,
   output logic [N*N-1:0]     o_matrix,
   output logic               turnoX,
   output logic               move_ack,
   output logic               move_reject,
   output logic               displayStartPlaying,
   output logic               displayGanadorX,
   output logic               displayGanadorO,
   output logic               displayEmpate,
   output logic [SCORE_W-1:0] scoreX,
   output logic [SCORE_W-1:0] scoreO,
   output logic [2:0]         state
);
   localparam int CELLS = N*N;
   localparam int CNT_W = $clog2(CELLS+1);
   localparam logic [CELLS-1:0] ONE = CELLS'(1);

   // state | meaning
   // START | title screen, waits for start
   // PLAY  | waiting for a move / undo
   // CHECK | scanning 4 directions through the last cell
   // WIN_X, WIN_O, TIE | game over, board frozen
   localparam logic [2:0] S_START = 3'd0;
   localparam logic [2:0] S_PLAY  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_WIN_X = 3'd3;
   localparam logic [2:0] S_WIN_O = 3'd4;
   localparam logic [2:0] S_TIE   = 3'd5;

   logic [2:0]         state_q, state_d;
   logic [CELLS-1:0]   x_q, x_d, o_q, o_d;
   logic               turn_q, turn_d, opener_q, opener_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   last_q, last_d, pop_idx;
   logic [IDX_W-1:0]   hist_q [CELLS];
   logic [IDX_W-1:0]   hist_d [CELLS];
   logic [1:0]         dir_q, dir_d;
   logic               win_q, win_d, ack_q, ack_d, rej_q, rej_d;
   logic [SCORE_W-1:0] sx_q, sx_d, so_q, so_d;
   logic [CELLS-1:0]   mine;
   logic               occupied, in_range, hit, fwd, bwd;
   int                 row, col, dr, dc, run;

   function automatic logic cell_at(input logic [CELLS-1:0] b, input int r, input int c);
      if (r < 0 || r >= N || c < 0 || c >= N) return 1'b0;
      return |(b & (ONE << (r*N + c)));
   endfunction

   // run length through last_q along the current direction, clipped at edges
   always_comb begin
      mine = turn_q ? x_q : o_q;
      row  = int'(last_q) / N;
      col  = int'(last_q) % N;
      dr   = 0;
      dc   = 1;
      case (dir_q)
         2'd1:    begin dr = 1; dc = 0;  end
         2'd2:    begin dr = 1; dc = 1;  end
         2'd3:    begin dr = 1; dc = -1; end
         default: ;
      endcase
      run = 1;
      fwd = 1'b1;
      bwd = 1'b1;
      for (int s = 1; s < K; s++) begin
         if (fwd && cell_at(mine, row + s*dr, col + s*dc)) run++;
         else fwd = 1'b0;
         if (bwd && cell_at(mine, row - s*dr, col - s*dc)) run++;
         else bwd = 1'b0;
      end
   end
   assign hit = (run >= K);

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      o_d      = o_q;
      turn_d   = turn_q;
      opener_d = opener_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      dir_d    = dir_q;
      win_d    = win_q;
      hist_d   = hist_q;
      ack_d    = 1'b0;
      rej_d    = 1'b0;
      sx_d     = sx_q;
      so_d     = so_q;
      pop_idx  = '0;
      for (int i = 0; i < CELLS; i++)
         if (CNT_W'(i+1) == cnt_q) pop_idx = hist_q[i];
      occupied = |((x_q | o_q) & (ONE << move_idx));
      in_range = int'(move_idx) < CELLS;

      case (state_q)
         S_START: if (start) state_d = S_PLAY;
         S_PLAY: begin
            if (erase) begin
               rej_d = move_valid;
               if (cnt_q != '0) begin
                  x_d    = x_q & ~(ONE << pop_idx);
                  o_d    = o_q & ~(ONE << pop_idx);
                  cnt_d  = cnt_q - CNT_W'(1);
                  turn_d = ~turn_q;
               end
            end else if (move_valid) begin
               if (in_range && !occupied) begin
                  if (turn_q) x_d = x_q | (ONE << move_idx);
                  else        o_d = o_q | (ONE << move_idx);
                  for (int i = 0; i < CELLS; i++)
                     if (CNT_W'(i) == cnt_q) hist_d[i] = move_idx;
                  cnt_d   = cnt_q + CNT_W'(1);
                  last_d  = move_idx;
                  dir_d   = 2'd0;
                  win_d   = 1'b0;
                  ack_d   = 1'b1;
                  state_d = S_CHECK;
               end else begin
                  rej_d = 1'b1;
               end
            end
         end
         S_CHECK: begin
            rej_d = move_valid;
            win_d = win_q | hit;
            dir_d = dir_q + 2'd1;
            if (dir_q == 2'd3) begin
               if (win_q | hit)              state_d = turn_q ? S_WIN_X : S_WIN_O;
               else if (int'(cnt_q) == CELLS) state_d = S_TIE;
               else begin
                  turn_d  = ~turn_q;
                  state_d = S_PLAY;
               end
            end
         end
         default: ;
      endcase

      // restart overrides whatever the current state decided
      if (restart && state_q != S_START) begin
         x_d      = '0;
         o_d      = '0;
         cnt_d    = '0;
         dir_d    = 2'd0;
         win_d    = 1'b0;
         ack_d    = 1'b0;
         rej_d    = 1'b0;
         opener_d = ~opener_q;
         turn_d   = ~opener_q;
         state_d  = S_PLAY;
      end

      if (score_clear) begin
         sx_d = '0;
         so_d = '0;
      end else begin
         if (state_d == S_WIN_X && state_q != S_WIN_X && sx_q != '1) sx_d = sx_q + SCORE_W'(1);
         if (state_d == S_WIN_O && state_q != S_WIN_O && so_q != '1) so_d = so_q + SCORE_W'(1);
      end
   end

   always_ff @(posedge CLK_100MHZ) begin
      if (reset) begin
         state_q  <= S_START;
         x_q      <= '0;
         o_q      <= '0;
         turn_q   <= 1'b1;
         opener_q <= 1'b1;
         cnt_q    <= '0;
         last_q   <= '0;
         dir_q    <= 2'd0;
         win_q    <= 1'b0;
         ack_q    <= 1'b0;
         rej_q    <= 1'b0;
         sx_q     <= '0;
         so_q     <= '0;
         for (int i = 0; i < CELLS; i++) hist_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         o_q      <= o_d;
         turn_q   <= turn_d;
         opener_q <= opener_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         dir_q    <= dir_d;
         win_q    <= win_d;
         ack_q    <= ack_d;
         rej_q    <= rej_d;
         sx_q     <= sx_d;
         so_q     <= so_d;
         for (int i = 0; i < CELLS; i++) hist_q[i] <= hist_d[i];
      end
   end

   assign x_matrix            = x_q;
   assign o_matrix            = o_q;
   assign turnoX              = turn_q;
   assign move_ack            = ack_q;
   assign move_reject         = rej_q;
   assign scoreX              = sx_q;
   assign scoreO              = so_q;
   assign state               = state_q;
   assign displayStartPlaying = (state_q == S_START);
   assign displayGanadorX     = (state_q == S_WIN_X);
   assign displayGanadorO     = (state_q == S_WIN_O);
   assign displayEmpate       = (state_q == S_TIE);
endmodule

// File: tb/tb_nxn_game_engine.sv
// Directed bench: a 3x3/K=3/2-bit-score instance and a 5x5/K=4 instance,
// hand-computed expectations for boards, turns, verdicts and scores.
module tb_nxn_game_engine;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, restart, erase, sclr;
   logic mv3, mv5;
   logic [3:0] idx3;
   logic [4:0] idx5;

   logic [8:0]  x3, o3;
   logic [24:0] x5, o5;
   logic t3, ack3, rej3, ds3, dx3, do3, de3;
   logic t5, ack5, rej5, ds5, dx5, do5, de5;
   logic [1:0] sx3, so3;
   logic [5:0] sx5, so5;
   logic [2:0] st3, st5;

   nxn_game_engine #(.N(3), .K(3), .SCORE_W(2)) dut3 (
      .CLK_100MHZ(clk), .reset(rst), .start(start), .move_valid(mv3), .move_idx(idx3),
      .erase(erase), .restart(restart), .score_clear(sclr),
      .x_matrix(x3), .o_matrix(o3), .turnoX(t3), .move_ack(ack3), .move_reject(rej3),
      .displayStartPlaying(ds3), .displayGanadorX(dx3), .displayGanadorO(do3),
      .displayEmpate(de3), .scoreX(sx3), .scoreO(so3), .state(st3));

   nxn_game_engine #(.N(5), .K(4), .SCORE_W(6)) dut5 (
      .CLK_100MHZ(clk), .reset(rst), .start(start), .move_valid(mv5), .move_idx(idx5),
      .erase(erase), .restart(restart), .score_clear(sclr),
      .x_matrix(x5), .o_matrix(o5), .turnoX(t5), .move_ack(ack5), .move_reject(rej5),
      .displayStartPlaying(ds5), .displayGanadorX(dx5), .displayGanadorO(do5),
      .displayEmpate(de5), .scoreX(sx5), .scoreO(so5), .state(st5));

   int n_chk  = 0;
   int n_pass = 0;

   int ga[5]  = '{0, 3, 1, 4, 2};
   int gb[6]  = '{3, 0, 4, 1, 8, 2};
   int gt[9]  = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
   int g5a[7] = '{1, 0, 7, 5, 13, 10, 19};
   int g5b[6] = '{24, 0, 20, 1, 15, 2};
   int g5c[7] = '{3, 24, 4, 23, 5, 22, 6};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // all tasks start and end at a falling edge
   task automatic mv(input int sel, input int idx);
      if (sel == 3) begin mv3 = 1'b1; idx3 = idx[3:0]; end
      else          begin mv5 = 1'b1; idx5 = idx[4:0]; end
      @(negedge clk);
      mv3 = 1'b0;
      mv5 = 1'b0;
   endtask

   task automatic play(input int sel, input int idx);
      mv(sel, idx);
      chk("move_ack", (sel == 3) ? ack3 : ack5, 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic strobe(input int w);
      case (w)
         0: start   = 1'b1;
         1: restart = 1'b1;
         default: erase = 1'b1;
      endcase
      @(negedge clk);
      start = 1'b0; restart = 1'b0; erase = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 0; restart = 0; erase = 0; sclr = 0;
      mv3 = 0; mv5 = 0; idx3 = '0; idx5 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst_state", st3, 0);
      chk("rst_board", {x3, o3}, 0);
      chk("rst_turn", t3, 1);
      chk("rst_disp", {ds3, dx3, do3, de3}, 4'b1000);
      chk("rst_score", {sx3, so3}, 0);
      chk("rst_ackrej", {ack3, rej3}, 0);

      mv(3, 0);
      chk("start_ignores_move", {ack3, rej3, st3}, 0);
      chk("start_board", x3, 0);
      strobe(0);
      chk("start_to_play3", st3, 1);
      chk("start_to_play5", st5, 1);

      // 5x5 K=4: diagonal win, then edge run of 3, then wrap-around guard
      foreach (g5a[i]) play(5, g5a[i]);
      chk("n5_diag_state", st5, 3);
      chk("n5_diag_score", sx5, 1);
      chk("n5_diag_disp", dx5, 1);
      strobe(1);
      chk("n5_restart_turn", t5, 0);
      chk("n5_restart_board", x5, 0);
      foreach (g5b[i]) play(5, g5b[i]);
      chk("n5_edge3_state", st5, 1);
      chk("n5_edge3_x", x5, 7);
      chk("n5_edge3_turn", t5, 0);
      strobe(1);
      chk("n5_opener_back", t5, 1);
      foreach (g5c[i]) play(5, g5c[i]);
      chk("n5_nowrap_state", st5, 1);
      chk("n5_nowrap_turn", t5, 0);

      // 3x3: X wins top row
      do_reset;
      strobe(0);
      play(3, 0);
      chk("turn_after_x", t3, 0);
      chk("play_after_check", st3, 1);
      for (int i = 1; i < 4; i++) play(3, ga[i]);
      mv(3, 2);
      chk("last_ack", ack3, 1);
      chk("in_check", st3, 2);
      repeat (3) @(negedge clk);
      chk("not_yet_verdict", st3, 2);
      @(negedge clk);
      chk("winx_state", st3, 3);
      chk("winx_score", {sx3, so3}, {2'd1, 2'd0});
      chk("winx_turn", t3, 1);
      chk("winx_board", {x3, o3}, {9'd7, 9'd24});
      chk("winx_disp", {ds3, dx3, do3, de3}, 4'b0100);
      mv(3, 5);
      chk("frozen_move", {ack3, rej3}, 0);
      strobe(2);
      chk("frozen_board", {x3, o3}, {9'd7, 9'd24});

      // tie, then restart hands the opening to O
      do_reset;
      strobe(0);
      foreach (gt[i]) play(3, gt[i]);
      chk("tie_state", st3, 5);
      chk("tie_disp", de3, 1);
      chk("tie_scores", {sx3, so3}, 0);
      chk("tie_board", {x3, o3}, {9'd397, 9'd114});
      strobe(1);
      chk("restart_state", st3, 1);
      chk("restart_board", {x3, o3}, 0);
      chk("restart_o_opens", t3, 0);

      // rejects
      play(3, 4);
      chk("o_played", {o3, t3}, {9'd16, 1'b1});
      mv(3, 4);
      chk("occupied_rej", {ack3, rej3}, 2'b01);
      chk("occupied_board", {x3, o3}, {9'd0, 9'd16});
      mv(3, 9);
      chk("range_rej", {ack3, rej3}, 2'b01);
      chk("range_board", {x3, o3}, {9'd0, 9'd16});
      mv3 = 1'b1; idx3 = 4'd0;
      @(negedge clk);
      chk("b2b_first_ack", {ack3, rej3}, 2'b10);
      idx3 = 4'd1;
      @(negedge clk);
      mv3 = 1'b0;
      chk("b2b_second_rej", {ack3, rej3}, 2'b01);
      chk("b2b_board", {x3, o3}, {9'd1, 9'd16});
      repeat (3) @(negedge clk);
      chk("b2b_back_to_play", {st3, t3}, {3'd1, 1'b0});
      mv3 = 1'b1; idx3 = 4'd2; erase = 1'b1;
      @(negedge clk);
      mv3 = 1'b0; erase = 1'b0;
      chk("erase_move_rej", {ack3, rej3}, 2'b01);
      chk("erase_move_board", {x3, o3}, {9'd0, 9'd16});
      chk("erase_move_turn", t3, 1);

      // undo stack
      do_reset;
      strobe(0);
      play(3, 0); play(3, 1); play(3, 2);
      strobe(2);
      chk("undo1", {x3, o3, t3}, {9'd1, 9'd2, 1'b1});
      strobe(2); strobe(2);
      chk("undo3", {x3, o3, t3}, {9'd0, 9'd0, 1'b1});
      strobe(2);
      chk("undo_empty", {x3, o3, t3, rej3, st3}, {9'd0, 9'd0, 1'b1, 1'b0, 3'd1});

      // 2-bit score saturation and score_clear vs increment
      do_reset;
      strobe(0);
      foreach (ga[i]) play(3, ga[i]);
      chk("sat_win1", sx3, 1);
      strobe(1);
      foreach (gb[i]) play(3, gb[i]);
      chk("sat_win2", {st3, sx3}, {3'd3, 2'd2});
      strobe(1);
      foreach (ga[i]) play(3, ga[i]);
      chk("sat_win3", sx3, 3);
      strobe(1);
      foreach (gb[i]) play(3, gb[i]);
      chk("sat_win4_hold", {st3, sx3}, {3'd3, 2'd3});
      strobe(1);
      for (int i = 0; i < 4; i++) play(3, ga[i]);
      mv(3, 2);
      repeat (3) @(negedge clk);
      sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0;
      chk("clear_beats_inc", {st3, sx3, so3}, {3'd3, 2'd0, 2'd0});

      // reset during CHECK
      strobe(1);
      mv(3, 4);
      chk("pre_reset_check", {ack3, st3}, {1'b1, 3'd2});
      do_reset;
      chk("rst_mid_check", {st3, x3, o3, t3, sx3, so3, ack3, rej3},
          {3'd0, 9'd0, 9'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0});
      chk("rst_mid_disp", {ds3, dx3, do3, de3}, 4'b1000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
